// File: rtl/fire6_squeeze_weight_sched_pkg.sv
// Shared types and layer constants for the fire6 squeeze weight sequencer.
package fire6_pkg;

  localparam int unsigned F6_SQ_NUM_CH = 384;
  localparam int unsigned F6_SQ_PIX    = 169;
  localparam int unsigned F6_SQ_ADDR   = 11;
  localparam int unsigned F6_SQ_LANES  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fire6_squeeze_weight_sched_if.sv
// Weight bus between the sequencer, the shared-address ROM bank and the MAC array.
interface fire6_squeeze_weight_sched_if #(
  parameter int unsigned ADDR = fire6_pkg::F6_SQ_ADDR
) ();

  logic [ADDR-1:0] rom_address;
  logic            w_valid;
  logic            w_first;
  logic            w_last;
  logic [15:0]     pix_idx;
  logic            mac_ready;

  modport master (
    output rom_address,
    output w_valid,
    output w_first,
    output w_last,
    output pix_idx,
    input  mac_ready
  );

  modport slave (
    input  rom_address,
    input  w_valid,
    input  w_first,
    input  w_last,
    input  pix_idx,
    output mac_ready
  );

endinterface

// File: rtl/fire6_squeeze_weight_sched_nested_cnt.sv
// Nested channel/pixel counter: inner wraps at INNER and carries into outer.
module wsched_nested_cnt #(
  parameter int unsigned INNER = 384,
  parameter int unsigned OUTER = 169,
  parameter int unsigned OW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [OW-1:0] o_outer,
  output logic          o_first,
  output logic          o_last,
  output logic          o_final
);

  localparam int unsigned IW = $clog2(INNER + 1);
  localparam logic [IW-1:0] INNER_LAST = IW'(INNER - 1);
  localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER - 1);

  logic [IW-1:0] r_inner;
  logic [OW-1:0] r_outer;
  logic          w_last;

  assign w_last = (r_inner == INNER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_clr) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_inc) begin
      if (w_last) begin
        r_inner <= '0;
        r_outer <= r_outer + OW'(1);
      end else begin
        r_inner <= r_inner + IW'(1);
      end
    end
  end

  assign o_outer = r_outer;
  assign o_first = (r_inner == '0);
  assign o_last  = w_last;
  assign o_final = w_last & (r_outer == OUTER_LAST);

endmodule

// File: rtl/fire6_squeeze_weight_sched.sv
// Fire6 squeeze weight sequencer: walks the channel range once per pixel and
// aligns valid/first/last/pix_idx with the 1-cycle registered ROM read.
module fire6_squeeze_weight_sched
  import fire6_pkg::*;
#(
  parameter int unsigned ADDR    = F6_SQ_ADDR,
  parameter int unsigned NUM_CH  = F6_SQ_NUM_CH,
  parameter int unsigned PIX_CNT = F6_SQ_PIX,
  parameter int unsigned BASE    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  fire6_squeeze_weight_sched_if.master  wb,
  output logic                          busy,
  output logic                          done
);

  localparam logic [ADDR-1:0] BASE_A = ADDR'(BASE);

  state_t          r_state;
  logic            r_w_valid;
  logic            r_busy;
  logic            r_done;
  logic [ADDR-1:0] r_cur_addr;

  logic            w_accept;
  logic            w_cnt_clr;
  logic            w_first;
  logic            w_last;
  logic            w_final;
  logic [15:0]     w_pix;
  logic [ADDR-1:0] w_next_addr;
  logic [ADDR-1:0] w_rom_address;

  assign w_accept  = r_w_valid & wb.mac_ready;
  assign w_cnt_clr = abort | (r_state == IDLE) | (w_accept & w_final);

  wsched_nested_cnt #(
    .INNER (NUM_CH),
    .OUTER (PIX_CNT),
    .OW    (16)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept),
    .i_clr   (w_cnt_clr),
    .o_outer (w_pix),
    .o_first (w_first),
    .o_last  (w_last),
    .o_final (w_final)
  );

  // Under stall the ROM re-reads the presented address so its output holds.
  always_comb begin
    w_next_addr   = w_last ? BASE_A : (r_cur_addr + ADDR'(1));
    w_rom_address = BASE_A;
    if (r_state == RUN) begin
      w_rom_address = w_accept ? w_next_addr : r_cur_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr <= BASE_A;
    end else begin
      r_cur_addr <= w_rom_address;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_w_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (abort) begin
      r_state   <= IDLE;
      r_w_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FILL;
            r_busy  <= 1'b1;
          end
        end
        FILL: begin
          r_state   <= RUN;
          r_w_valid <= 1'b1;
        end
        RUN: begin
          if (w_accept && w_final) begin
            r_state   <= DONE;
            r_w_valid <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_w_valid <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign wb.rom_address = w_rom_address;
  assign wb.w_valid     = r_w_valid;
  assign wb.w_first     = r_w_valid & w_first;
  assign wb.w_last      = r_w_valid & w_last;
  assign wb.pix_idx     = r_w_valid ? w_pix : '0;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: doc/fire6_squeeze_weight_sched.md
Name: fire6_squeeze_weight_sched

Overview:
- Sequencer for the fire6 squeeze weight ROM bank: 64 parallel 16-bit ROMs sharing one address bus, with 1-cycle registered read.
- Walks the input-channel address range once per output pixel and aligns a valid/first/last sideband with the registered ROM data.
- Backpressure from the 64-lane MAC array stalls the sequence; the ROM data stays stable under stall.
- Sits between the layer top-level FSM (start/done) and the ROM bank plus MAC array.

Parameters:
- ADDR, 11, ROM address width; must match the ROM bank.
- NUM_CH, 384, weights per filter (input channels), 1..2**ADDR.
- PIX_CNT, 169, output pixels per layer pass, 1..65535.
- BASE, 0, first ROM address of the weight block; BASE+NUM_CH-1 must not exceed 2**ADDR-1.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a layer pass; sampled only in IDLE.
- abort, in, 1: synchronous cancel; highest priority outside reset.
- mac_ready, in, 1: MAC array accepts the presented beat.
- rom_address, out, ADDR: address bus to the ROM bank.
- w_valid, out, 1: ROM data (rom_out) this cycle is a valid beat.
- w_first, out, 1: beat is channel 0 (MAC clears its accumulator).
- w_last, out, 1: beat is channel NUM_CH-1 (MAC flushes pixel result).
- pix_idx, out, 16: pixel index of the presented beat.
- busy, out, 1: high from the cycle after start through DONE.
- done, out, 1: one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; rom_address=BASE; state=IDLE.
  - Channel and pixel counters = 0.
- States: IDLE, FILL, RUN, DONE.
- IDLE:
  - rom_address=BASE, w_valid=0.
  - start=1 -> FILL; counters cleared.
- FILL:
  - Lasts exactly one cycle; the ROM registers rom[BASE].
  - Go to RUN.
  - w_valid=1 on the first RUN cycle, i.e. latency start -> first beat = 2 cycles.
- RUN:
  - Beat accepted when w_valid & mac_ready.
  - Internal register cur_addr holds the address of the presented beat.
  - Stall (w_valid & !mac_ready): rom_address=cur_addr (combinational). The ROM re-reads it, so rom_out, w_first, w_last and pix_idx hold. Counters hold.
  - Accept:
    - rom_address = next address: cur_addr+1, or BASE when ch==NUM_CH-1.
    - ch increments; on wrap to 0, pix increments.
  - cur_addr <= rom_address every cycle.
- Sideband:
  - w_first = (ch==0) and w_last = (ch==NUM_CH-1), for the presented beat.
  - NUM_CH=1: w_first and w_last are both high on every beat.
- Final beat: accept with ch==NUM_CH-1 and pix==PIX_CNT-1 -> DONE.
  - w_valid=0 in DONE; no extra beat is issued.
- DONE:
  - done=1 and busy=1 for one cycle; then IDLE.
- start:
  - Ignored outside IDLE.
  - start in the DONE cycle is ignored. The top FSM re-asserts it in IDLE.
- abort=1 in any state:
  - Next state is IDLE; w_valid, busy and done go 0 next cycle.
  - Counters cleared; done is not pulsed.
  - A beat accepted in the same cycle as abort is still consumed by the MAC; the MAC drops partial sums on abort.
- Counter widths:
  - ch: clog2(NUM_CH+1) bits.
  - pix: 16 bits.
  - Address arithmetic: ADDR bits, never wraps past BASE+NUM_CH-1.
- mac_ready while w_valid=0: ignored.

Decomposition:
- Shared package fire6_pkg:
  - typedef state_t (IDLE/FILL/RUN/DONE).
  - Constants F6_SQ_NUM_CH=384, F6_SQ_PIX=169, F6_SQ_ADDR=11, F6_SQ_LANES=64.
- One natural sub-module: wsched_nested_cnt.
  - Ports: inc, clr, wrap flags.
  - Parameterised inner/outer terminal counts.
  - Holds ch/pix and produces first/last/final.
- FSM and address mux stay in the top.

Test Plan:
- NUM_CH=4, PIX_CNT=2, BASE=8, mac_ready=1, start pulse at cycle 0:
  - rom_address 8,9,10,11,8,9,10,11.
  - w_valid cycles 2..9.
  - w_first at cycles 2 and 6; w_last at cycles 5 and 9.
  - pix_idx 0,0,0,0,1,1,1,1.
  - done at cycle 10.
- Same config, mac_ready=0 at cycles 3-5:
  - rom_address=9 during the stall; the beat at addr 9 is held for 4 cycles.
  - Sequence resumes 10,11; done is 3 cycles late (cycle 13).
- NUM_CH=1, PIX_CNT=3:
  - rom_address constant BASE.
  - 3 beats, each with w_first=w_last=1.
  - done 1 cycle after the 3rd accept.
- abort at the second beat of pixel 1:
  - Next cycle: w_valid=0, busy=0, no done.
  - A new start gives rom_address=BASE and pix_idx=0.
- rst_n low mid-RUN (asynchronous, between edges):
  - Outputs 0 immediately; rom_address=BASE.
  - After release, start is required before any w_valid.
- start held high continuously:
  - Exactly one pass per IDLE visit.
  - Passes separated by the DONE and IDLE cycles.
  - start during RUN has no effect.
